// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel strobe, syncs, blanking,
// active coordinates and tile addressing. Define VGA_TEST_PATTERN_EN for an rgb colour-bar output.
module vga_timing_gen #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_PULSE    = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_PULSE    = 2,
    parameter int V_BACK     = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int CNT_W      = 10,
    parameter int TILE_SHIFT = 3,
    parameter int ADDR_W     = 16
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  enable,
    output logic                  pix_en,
    output logic                  hSync,
    output logic                  vSync,
    output logic                  bright,
    output logic [CNT_W-1:0]      hCount,
    output logic [CNT_W-1:0]      vCount,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [ADDR_W-1:0]     tile_addr,
    output logic [TILE_SHIFT-1:0] tile_px,
    output logic [TILE_SHIFT-1:0] tile_py
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [7:0]            rgb
`endif
);

    localparam int H_TOT = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOT = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0]  V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0]  H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]  HS_START = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0]  HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_PULSE);
    localparam logic [CNT_W-1:0]  VS_START = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0]  VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_PULSE);
    localparam logic [ADDR_W-1:0] TILES_X  = ADDR_W'(H_ACTIVE >> TILE_SHIFT);

    logic [DIV_W-1:0]  div;
    logic [CNT_W-1:0]  hc;
    logic [CNT_W-1:0]  vc;
    logic              stb;
    logic              hs_act;
    logic              vs_act;
    logic              act;
    logic [ADDR_W-1:0] tile_addr_d;

    assign stb = enable && (div == DIV_LAST);

    // Raster position; a disabled generator parks the divider so the next
    // strobe is a full CLK_DIV clocks after enable returns.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            div <= '0;
            hc  <= '0;
            vc  <= '0;
        end else if (!enable) begin
            div <= '0;
        end else if (stb) begin
            div <= '0;
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        hs_act      = (hc >= HS_START) && (hc < HS_END);
        vs_act      = (vc >= VS_START) && (vc < VS_END);
        act         = (hc < H_ACT_C) && (vc < V_ACT_C);
        tile_addr_d = ADDR_W'(vc >> TILE_SHIFT) * TILES_X + ADDR_W'(hc >> TILE_SHIFT);
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            pix_en      <= 1'b0;
            hSync       <= ~HSYNC_POL;
            vSync       <= ~VSYNC_POL;
            bright      <= 1'b0;
            hCount      <= '0;
            vCount      <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            tile_addr   <= '0;
            tile_px     <= '0;
            tile_py     <= '0;
        end else begin
            pix_en      <= stb;
            hSync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vSync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            bright      <= act && enable;
            hCount      <= act ? hc : '0;
            vCount      <= act ? vc : '0;
            line_start  <= stb && (hc == '0);
            frame_start <= stb && (hc == '0) && (vc == '0);
            tile_addr   <= act ? tile_addr_d : '0;
            tile_px     <= act ? hc[TILE_SHIFT-1:0] : '0;
            tile_py     <= act ? vc[TILE_SHIFT-1:0] : '0;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Eight equal vertical bars; leftover pixels of a non-multiple-of-8 width join the last bar.
    localparam int BAR_PX = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [CNT_W-1:0] BAR_PX_C = CNT_W'(BAR_PX);
    localparam logic [CNT_W-1:0] BAR_MAX  = CNT_W'(7);

    logic [CNT_W-1:0] bar_q;
    logic [2:0]       bar;
    logic [7:0]       colour;

    always_comb begin
        bar_q = hc / BAR_PX_C;
        bar   = (bar_q > BAR_MAX) ? 3'd7 : bar_q[2:0];
        case (bar)
            3'd0:    colour = 8'h00;
            3'd1:    colour = 8'h03;
            3'd2:    colour = 8'h1C;
            3'd3:    colour = 8'h1F;
            3'd4:    colour = 8'hE0;
            3'd5:    colour = 8'hE3;
            3'd6:    colour = 8'hFC;
            default: colour = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) rgb <= 8'h00;
        else        rgb <= (act && enable) ? colour : 8'h00;
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster, checked every clock
// against a pixel-position model; VGA_TEST_PATTERN_EN also checks rgb.
module tb_vga_timing_gen;

    localparam int CLK_DIV    = 2;
    localparam int H_ACTIVE   = 32;
    localparam int H_FRONT    = 4;
    localparam int H_PULSE    = 6;
    localparam int H_BACK     = 5;
    localparam int V_ACTIVE   = 16;
    localparam int V_FRONT    = 2;
    localparam int V_PULSE    = 3;
    localparam int V_BACK     = 2;
    localparam bit HSYNC_POL  = 1'b0;
    localparam bit VSYNC_POL  = 1'b1;
    localparam int CNT_W      = 8;
    localparam int TILE_SHIFT = 2;
    localparam int ADDR_W     = 5;
    localparam int H_TOT      = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOT      = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;
    localparam int FRAME_PX   = H_TOT * V_TOT;

    logic                  clk = 1'b0;
    logic                  clear = 1'b0;
    logic                  enable = 1'b0;
    logic                  pix_en, hSync, vSync, bright, line_start, frame_start;
    logic [CNT_W-1:0]      hCount, vCount;
    logic [ADDR_W-1:0]     tile_addr;
    logic [TILE_SHIFT-1:0] tile_px, tile_py;
`ifdef VGA_TEST_PATTERN_EN
    logic [7:0]            rgb;
`endif

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_PULSE(H_PULSE),
        .H_BACK(H_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_PULSE(V_PULSE),
        .V_BACK(V_BACK), .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL), .CNT_W(CNT_W),
        .TILE_SHIFT(TILE_SHIFT), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .clear(clear), .enable(enable), .pix_en(pix_en), .hSync(hSync),
        .vSync(vSync), .bright(bright), .hCount(hCount), .vCount(vCount),
        .line_start(line_start), .frame_start(frame_start), .tile_addr(tile_addr),
        .tile_px(tile_px), .tile_py(tile_py)
`ifdef VGA_TEST_PATTERN_EN
        , .rgb(rgb)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: pos counts strobed pixels into the frame, run counts enabled clocks since the last strobe.
    int pos = 0;
    int run = 0;
    logic [31:0] e_pix_en, e_hsync, e_vsync, e_bright, e_hcount, e_vcount;
    logic [31:0] e_line, e_frame, e_taddr, e_tpx, e_tpy, e_rgb;
    logic [7:0]  palette [8] = '{8'h00, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF};

    bit measure = 0;
    int last_ls, last_fs, hs_run, vs_run, br_run;
    bit seen_pix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pos = 0; run = 0;
        e_pix_en = 0; e_bright = 0; e_line = 0; e_frame = 0;
        e_hsync = 32'(!HSYNC_POL); e_vsync = 32'(!VSYNC_POL);
        e_hcount = 0; e_vcount = 0; e_taddr = 0; e_tpx = 0; e_tpy = 0; e_rgb = 0;
    endtask

    task automatic model_edge();
        int  x, y, bar;
        bit  in_act, stb;
        if (!clear) begin
            model_reset();
            return;
        end
        x      = pos % H_TOT;
        y      = pos / H_TOT;
        in_act = (x < H_ACTIVE) && (y < V_ACTIVE);
        stb    = enable && (run == CLK_DIV - 1);
        e_pix_en = 32'(stb);
        e_hsync  = (x >= H_ACTIVE + H_FRONT && x < H_ACTIVE + H_FRONT + H_PULSE)
                   ? 32'(HSYNC_POL) : 32'(!HSYNC_POL);
        e_vsync  = (y >= V_ACTIVE + V_FRONT && y < V_ACTIVE + V_FRONT + V_PULSE)
                   ? 32'(VSYNC_POL) : 32'(!VSYNC_POL);
        e_bright = 32'(in_act && enable);
        e_hcount = in_act ? 32'(x) : 0;
        e_vcount = in_act ? 32'(y) : 0;
        e_taddr  = in_act ? 32'(((y >> TILE_SHIFT) * (H_ACTIVE >> TILE_SHIFT) + (x >> TILE_SHIFT))
                                % (1 << ADDR_W)) : 0;
        e_tpx    = in_act ? 32'(x % (1 << TILE_SHIFT)) : 0;
        e_tpy    = in_act ? 32'(y % (1 << TILE_SHIFT)) : 0;
        e_line   = 32'(stb && x == 0);
        e_frame  = 32'(stb && pos == 0);
        bar      = x / (H_ACTIVE / 8);
        if (bar > 7) bar = 7;
        e_rgb    = (in_act && enable) ? 32'(palette[bar]) : 0;
        if (!enable) run = 0;
        else if (stb) begin
            run = 0;
            pos = (pos + 1) % FRAME_PX;
        end else run++;
    endtask

    task automatic check_output(input string where);
        check({where, ".pix_en"}, 32'(pix_en), e_pix_en);
        check({where, ".hSync"}, 32'(hSync), e_hsync);
        check({where, ".vSync"}, 32'(vSync), e_vsync);
        check({where, ".bright"}, 32'(bright), e_bright);
        check({where, ".hCount"}, 32'(hCount), e_hcount);
        check({where, ".vCount"}, 32'(vCount), e_vcount);
        check({where, ".line_start"}, 32'(line_start), e_line);
        check({where, ".frame_start"}, 32'(frame_start), e_frame);
        check({where, ".tile_addr"}, 32'(tile_addr), e_taddr);
        check({where, ".tile_px"}, 32'(tile_px), e_tpx);
        check({where, ".tile_py"}, 32'(tile_py), e_tpy);
`ifdef VGA_TEST_PATTERN_EN
        check({where, ".rgb"}, 32'(rgb), e_rgb);
`endif
    endtask

    // Period and pulse-width measurements taken purely from observed outputs.
    task automatic measure_outputs();
        if (line_start) begin
            if (last_ls >= 0) check("line_start_period", 32'(cyc - last_ls), 32'(H_TOT * CLK_DIV));
            last_ls = cyc;
        end
        if (frame_start) begin
            check("frame_implies_line", 32'(line_start), 32'd1);
            if (last_fs >= 0) check("frame_start_period", 32'(cyc - last_fs), 32'(FRAME_PX * CLK_DIV));
            last_fs = cyc;
        end
        if (pix_en && !seen_pix) begin
            check("first_pix_is_frame_start", 32'(frame_start), 32'd1);
            seen_pix = 1;
        end
        if (hSync == HSYNC_POL) hs_run++;
        else if (hs_run > 0) begin
            check("hsync_width", 32'(hs_run), 32'(H_PULSE * CLK_DIV));
            hs_run = 0;
        end
        if (vSync == VSYNC_POL) vs_run++;
        else if (vs_run > 0) begin
            check("vsync_width", 32'(vs_run), 32'(V_PULSE * H_TOT * CLK_DIV));
            vs_run = 0;
        end
        if (bright) br_run++;
        else if (br_run > 0) begin
            check("bright_width", 32'(br_run), 32'(H_ACTIVE * CLK_DIV));
            br_run = 0;
        end
    endtask

    task automatic apply_stimulus(input bit en, input bit clr_n, input string where);
        enable = en;
        clear  = clr_n;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_output(where);
        if (measure) measure_outputs();
    endtask

    task automatic async_clear(input string where);
        clear = 1'b0;
        #1;
        model_reset();
        check_output(where);
    endtask

    initial begin
        int  frozen_pos, pix_seen, bright_seen;
        bit  found;

        model_reset();
        $display("[TB] reset held for 5 clocks");
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, "reset");

        $display("[TB] free run, three frames with period measurements");
        last_ls = -1; last_fs = -1; hs_run = 0; vs_run = 0; br_run = 0; seen_pix = 0;
        measure = 1;
        for (int i = 0; i < 3 * FRAME_PX * CLK_DIV + 10; i++) apply_stimulus(1'b1, 1'b1, "free");
        measure = 0;

        $display("[TB] last active pixel and the blanked pixel after it");
        found = 0;
        for (int i = 0; i < 2 * FRAME_PX * CLK_DIV && !found; i++) begin
            if (pos == (V_ACTIVE - 1) * H_TOT + H_ACTIVE - 1 && run == CLK_DIV - 1) found = 1;
            else apply_stimulus(1'b1, 1'b1, "seek_corner");
        end
        check("corner_reached", 32'(found), 32'd1);
        apply_stimulus(1'b1, 1'b1, "corner");
        check("corner.bright", 32'(bright), 32'd1);
        check("corner.hCount", 32'(hCount), 32'(H_ACTIVE - 1));
        check("corner.vCount", 32'(vCount), 32'(V_ACTIVE - 1));
        check("corner.tile_addr", 32'(tile_addr), 32'd31);
        check("corner.tile_px", 32'(tile_px), 32'd3);
        check("corner.tile_py", 32'(tile_py), 32'd3);
        for (int i = 0; i < CLK_DIV; i++) apply_stimulus(1'b1, 1'b1, "after_corner");
        check("after_corner.bright", 32'(bright), 32'd0);
        check("after_corner.hCount", 32'(hCount), 32'd0);
        check("after_corner.tile_addr", 32'(tile_addr), 32'd0);

        $display("[TB] freeze for 50 clocks at x=10 of line 3");
        found = 0;
        for (int i = 0; i < 2 * FRAME_PX * CLK_DIV && !found; i++) begin
            if (pos == 3 * H_TOT + 10 && run == 0) found = 1;
            else apply_stimulus(1'b1, 1'b1, "seek_freeze");
        end
        check("freeze_reached", 32'(found), 32'd1);
        frozen_pos = pos;
        pix_seen = 0; bright_seen = 0;
        for (int i = 0; i < 50; i++) begin
            apply_stimulus(1'b0, 1'b1, "frozen");
            pix_seen    += int'(pix_en);
            bright_seen += int'(bright);
        end
        check("frozen.pix_en_count", 32'(pix_seen), 32'd0);
        check("frozen.bright_count", 32'(bright_seen), 32'd0);
        check("frozen.hold_position", 32'(pos), 32'(frozen_pos));
        for (int i = 0; i < CLK_DIV; i++) apply_stimulus(1'b1, 1'b1, "resume");
        check("resume.pix_en", 32'(pix_en), 32'd1);
        check("resume.hCount", 32'(hCount), 32'd10);
        for (int i = 0; i < CLK_DIV; i++) apply_stimulus(1'b1, 1'b1, "resume_next");
        check("resume_next.hCount", 32'(hCount), 32'd11);

        $display("[TB] mid-frame asynchronous clear");
        for (int i = 0; i < 37; i++) apply_stimulus(1'b1, 1'b1, "pre_clear");
        async_clear("mid_clear");
        apply_stimulus(1'b1, 1'b0, "clear_held");
        for (int i = 0; i < 4 * CLK_DIV; i++) apply_stimulus(1'b1, 1'b1, "post_clear");

        $display("[TB] randomized enable with occasional clear pulses");
        for (int i = 0; i < 16000; i++) begin
            if ($urandom_range(0, 1999) == 0) begin
                async_clear("rand_clear");
                apply_stimulus(1'b1, 1'b0, "rand_clear_held");
            end
            apply_stimulus($urandom_range(0, 7) != 0, 1'b1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; next generation of the fixed 640x480 sync controller.
- Generates pixel strobe, hSync, vSync and bright, plus active-area coordinates, line/frame start pulses and row-major tile address for glyph/tile memory lookup.
- Sits between the system clock domain and the pixel/tile memory and colour logic.
- All sync/porch widths, polarities, clock division and tile size are parameters.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=1)
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_PULSE, 96, hSync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_PULSE, 2, vSync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hSync
- VSYNC_POL, 0, asserted level of vSync
- CNT_W, 10, width of h/v counters and coordinate outputs
- TILE_SHIFT, 3, log2 of tile edge in pixels
- ADDR_W, 16, tile address width

Ports:
- clk  in  1  system clock
- clear  in  1  asynchronous active-low reset
- enable  in  1  run/freeze control
- pix_en  out  1  pixel strobe, one clk wide
- hSync  out  1  horizontal sync
- vSync  out  1  vertical sync
- bright  out  1  high inside the active area
- hCount  out  CNT_W  active x (0..H_ACTIVE-1); 0 outside active area
- vCount  out  CNT_W  active y (0..V_ACTIVE-1); 0 outside active area
- line_start  out  1  pulse at pixel 0 of every line
- frame_start  out  1  pulse at pixel 0 of line 0
- tile_addr  out  ADDR_W  (y>>TILE_SHIFT)*(H_ACTIVE>>TILE_SHIFT) + (x>>TILE_SHIFT)
- tile_px  out  TILE_SHIFT  x within tile
- tile_py  out  TILE_SHIFT  y within tile

Behaviour:
- Internal state: divider div (0..CLK_DIV-1), hc (0..H_TOT-1), vc (0..V_TOT-1).
  - H_TOT = H_ACTIVE+H_FRONT+H_PULSE+H_BACK.
  - V_TOT = V_ACTIVE+V_FRONT+V_PULSE+V_BACK.
- Strobe and counter stepping:
  - stb = enable && (div == CLK_DIV-1); with CLK_DIV=1, stb = enable.
  - div increments each clk while enable=1 and wraps to 0 after CLK_DIV-1.
  - On stb: hc increments; at H_TOT-1 it wraps to 0 and vc increments in the same cycle; vc wraps to 0 after V_TOT-1.
- Per-line order: active, front porch, sync, back porch. Vertical order is the same.
- Decode:
  - hs_act = hc in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_PULSE).
  - vs_act = vc in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_PULSE).
  - act = hc<H_ACTIVE && vc<V_ACTIVE.
- Output registers (all outputs, latency exactly one clk from internal state):
  - pix_en <= stb.
  - hSync <= hs_act ? HSYNC_POL : ~HSYNC_POL; vSync likewise with VSYNC_POL.
  - bright <= act && enable.
  - hCount/vCount <= act ? hc/vc : 0.
  - tile_addr, tile_px, tile_py <= act ? value : 0. tile_addr is truncated modulo 2^ADDR_W; the multiply is by a constant.
  - line_start <= stb && hc==0; frame_start <= stb && hc==0 && vc==0.
- enable=0:
  - div forced to 0; hc and vc hold.
  - Sync outputs keep their decoded levels.
  - bright, pix_en, line_start and frame_start are 0.
  - When enable returns to 1, counting resumes from the held hc/vc; the first stb comes CLK_DIV clks later.
- Reset (clear=0, asynchronous, any time including mid-frame):
  - div, hc, vc = 0.
  - hSync = ~HSYNC_POL, vSync = ~VSYNC_POL.
  - bright, pix_en, line_start, frame_start = 0; hCount, vCount, tile_* = 0.
  - Outputs take these values immediately, without a clk edge.
  - After release, the first stb has hc=vc=0, so the first frame_start follows CLK_DIV clks after release (+1 register stage).
- Simultaneous events: an hc wrap and a vc wrap on the same stb both apply in that cycle. frame_start implies line_start.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- When defined:
  - Adds output rgb[7:0] (3-3-2 RGB), registered with the same one-clk latency.
  - Eight vertical bars, each H_ACTIVE/8 wide: black, blue, green, cyan, red, magenta, yellow, white (00, 03, 1C, 1F, E0, E3, FC, FF).
  - rgb = 0 whenever bright would be 0.
- When undefined: the rgb port and its logic are absent.

Test Plan:
- Defaults, release clear after 5 clks -> pix_en every 2nd clk; first frame_start coincides with first pix_en; line_start period 1600 clks.
- Line timing -> hSync low for exactly 192 clks, falling at hc=656; bright high for 1280 clks per active line.
- Frame timing -> vSync low for 2 lines starting at line 490; frame_start period 840000 clks.
- Pixel (639,479) -> bright=1, hCount=639, vCount=479, tile_addr=4799, tile_px=7, tile_py=7; next pixel -> bright=0, hCount=0, tile_addr=0.
- enable low for 50 clks at hc=100 (line 3) -> no pix_en, bright=0, hc holds; resumes at hc=101; clear pulsed low mid-frame -> all outputs reset with no clk edge.
- VGA_TEST_PATTERN_EN defined: hCount=80 -> rgb=03; hCount=639 -> rgb=FF; blanking -> rgb=00.
